bcd2binary_reverse_dabble: RTL and testbench
============================================

# bcd2binary_reverse_dabble

Sequential packed-BCD to binary converter using the reverse double-dabble algorithm: shift right one bit per cycle, then subtract 3 from every BCD digit that is 8 or more. It is the decode-direction companion to the team's binary-to-BCD converter, for example to turn keypad or seven-segment-domain decimal values back into arithmetic binary. Input and output use valid/ready handshakes. One conversion is in flight at a time.

## Interface
- DIGITS, 3, number of packed BCD digits in; BCD width is 4*DIGITS.
- BIN_W, 10, binary result width; must satisfy 10^DIGITS − 1 < 2^BIN_W (elaboration error otherwise).
- clk  input  1  single clock; all state is rising-edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  bcd_in is valid.
- in_ready  output  1  block can accept; high only in IDLE.
- bcd_in  input  4*DIGITS  packed BCD, digit 0 in [3:0].
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts result.
- binary_out  output  BIN_W  converted value.
- bcd_err  output  1  some input digit exceeded 9; qualified by out_valid.

## Operation
- State machine has three states:
  - IDLE: in_ready=1. On in_valid&&in_ready, load the work register {bcd_in, BIN_W'b0}, clear cnt, latch err = OR over digits of (digit>9), and go to CONV.
  - CONV: each cycle, shift the work register right 1 bit, then for each BCD digit field, if the shifted digit ≥ 8, subtract 3. Digits are adjusted independently and all in the same cycle. cnt increments. When cnt == BIN_W−1, go to DONE.
  - DONE: out_valid=1. binary_out = err ? 0 : low BIN_W bits of the work register. bcd_err = err. On out_valid&&out_ready, go to IDLE.
- When the input is valid, the BCD field is zero after BIN_W shifts. No overflow is possible.
- With an invalid digit, the conversion still runs the full BIN_W cycles, which keeps latency fixed. The reported binary_out is 0 and bcd_err is 1.
- bcd_in is sampled only at the acceptance edge. Later changes to it are ignored.
- in_valid is ignored outside IDLE. Upstream must hold the request until in_ready.

## Timing
- Reset (rst_n low, asynchronous) drives:
  - state=IDLE
  - in_ready=1
  - out_valid=0
  - binary_out=0
  - bcd_err=0
  - work register and cnt = 0
- rst_n low mid-CONV or in DONE: the conversion is dropped immediately and no result is produced.
- Latency: acceptance at edge k gives CONV on edges k+1…k+BIN_W. out_valid is high after edge k+BIN_W, which is 10 cycles for the defaults.
- The earliest next acceptance is edge k+BIN_W+2 (out_ready tied high). Throughput is 1 per BIN_W+2 cycles.
- In DONE with out_ready low, out_valid, binary_out and bcd_err hold stable indefinitely.
- After the output handshake edge:
  - out_valid=0 and in_ready=1 the next cycle.
  - binary_out and bcd_err keep their last value, but are don't-care while out_valid=0.
- No combinational path from inputs to outputs. in_ready and out_valid decode from registered state only.

## Test plan
- Reset, then bcd_in=12'h000 → out_valid rises exactly 10 cycles after acceptance, with binary_out=10'd0 and bcd_err=0.
- Directed values, each checked for the exact 10-cycle latency:
  - 12'h255 → 10'd255
  - 12'h999 → 10'd999
  - 12'h010 → 10'd10
  - 12'h128 → 10'd128
- Exhaustive sweep of 12'h000…12'h999 (1000 valid codes), out_ready=1 → each binary_out equals the decimal value; 0 errors.
- Invalid digit 12'h1A3, then 12'hF00 → bcd_err=1 and binary_out=0, latency unchanged. The next valid input 12'h042 → 10'd42 with bcd_err=0.
- Backpressure: hold out_ready=0 for 7 cycles after out_valid on input 12'h777 → outputs stay at 10'd777 and in_ready=0 throughout. A new in_valid during the stall is not accepted. Raise out_ready → in_ready=1 one cycle later.
- Pull rst_n low 4 cycles into CONV for 12'h500, release, then send 12'h003 → no result for 500 ever appears; reset values are observed; the next result is 10'd3.

Source files
------------

// File: rtl/bcd2binary_reverse_dabble.sv
// Sequential packed-BCD to binary converter using reverse double dabble.
// A conversion shifts the {bcd, binary} work register right once per cycle and
// corrects every BCD digit that lands at 8 or more by subtracting 3. One
// conversion is in flight at a time; input and output use valid/ready.
module bcd2binary_reverse_dabble #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      binary_out,
  output logic                  bcd_err
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  // Largest decimal value plus one; used only for the width sanity check.
  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  // The binary result must hold 10^DIGITS - 1, i.e. 10^DIGITS <= 2^BIN_W.
  if (pow10(DIGITS) > (64'd1 << BIN_W)) begin : g_width_check
    $error("BIN_W too small to hold the largest %0d-digit decimal value", DIGITS);
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [WORK_W-1:0]   work;
  logic [CNT_W-1:0]    cnt;
  logic                err;
  logic [WORK_W-1:0]   dabble_next;
  logic                any_bad_digit;

  // Handshake flags decode straight from the registered state.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Flag any input digit outside 0..9; only consumed at the acceptance edge.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    any_bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) any_bad_digit = 1'b1;
    end
  end

  // One reverse-dabble step: shift right, then pull each digit >= 8 down by 3.
  always_comb begin
    dabble_next = work >> 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (dabble_next[BIN_W + 4*i +: 4] >= 4'd8)
        dabble_next[BIN_W + 4*i +: 4] = dabble_next[BIN_W + 4*i +: 4] - 4'd3;
    end
  end

  // Control FSM plus datapath registers; results are captured on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values, independent of statement order.
      state      <= IDLE;
      work       <= '0;
      cnt        <= '0;
      err        <= 1'b0;
      binary_out <= '0;
      bcd_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= {bcd_in, {BIN_W{1'b0}}};
            cnt   <= '0;
            err   <= any_bad_digit;
            state <= CONV;
          end
        end
        CONV: begin
          work <= dabble_next;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            // Invalid inputs still run the full length but report zero.
            binary_out <= err ? '0 : dabble_next[BIN_W-1:0];
            bcd_err    <= err;
            state      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2binary_reverse_dabble.sv
// Directed and sweep bench for bcd2binary_reverse_dabble. Expected results are
// queued when a request is driven and popped when out_valid is observed.
module tb_bcd2binary_reverse_dabble;

  localparam int DIGITS  = 3;
  localparam int BIN_W   = 10;
  localparam int LATENCY = BIN_W;

  typedef struct packed {
    logic [BIN_W-1:0] bin;
    logic             err;
  } exp_t;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [4*DIGITS-1:0] bcd_in;
  logic                out_valid;
  logic                out_ready;
  logic [BIN_W-1:0]    binary_out;
  logic                bcd_err;

  int   checks;
  int   errors;
  exp_t sb_q[$];

  bcd2binary_reverse_dabble #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .bcd_in     (bcd_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .binary_out (binary_out),
    .bcd_err    (bcd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: decimal value of a packed BCD word, or error for bad digits.
  function automatic exp_t model(input logic [4*DIGITS-1:0] bcd);
    exp_t r;
    int   val;
    logic [3:0] d;
    val   = 0;
    r.err = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = bcd[4*i +: 4];
      if (d > 4'd9) r.err = 1'b1;
      val = val * 10 + int'(d);
    end
    r.bin = r.err ? '0 : BIN_W'(val);
    return r;
  endfunction

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] b;
    int t;
    t = v;
    b = '0;
    for (int i = 0; i < DIGITS; i++) begin
      b[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request (accepted at the next edge), then scramble bcd_in.
  task automatic drive(input logic [4*DIGITS-1:0] bcd, input exp_t exp);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin tick(); w++; end
    check("in_ready_before_send", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    bcd_in   = bcd;
    sb_q.push_back(exp);
    tick();
    in_valid = 1'b0;
    bcd_in   = ~bcd;
  endtask

  // Wait for out_valid, checking exact latency, and return the popped expectation.
  task automatic await_result(input string tag, output exp_t exp);
    int lat;
    lat = 0;
    while (!out_valid && lat < 2 * LATENCY) begin tick(); lat++; end
    check({tag, "_latency"}, lat, LATENCY);
    if (sb_q.size() > 0) exp = sb_q.pop_front();
    else begin
      exp = '0;
      check({tag, "_scoreboard_nonempty"}, 32'd0, 32'd1);
    end
    check({tag, "_binary_out"}, {22'd0, binary_out}, {22'd0, exp.bin});
    check({tag, "_bcd_err"}, {31'd0, bcd_err}, {31'd0, exp.err});
  endtask

  task automatic convert(input string tag, input logic [4*DIGITS-1:0] bcd, input exp_t exp);
    exp_t got_exp;
    drive(bcd, exp);
    await_result(tag, got_exp);
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},   {31'd0, in_ready},   32'd1);
    check({tag, "_out_valid"},  {31'd0, out_valid},  32'd0);
    check({tag, "_binary_out"}, {22'd0, binary_out}, 32'd0);
    check({tag, "_bcd_err"},    {31'd0, bcd_err},    32'd0);
  endtask

  initial begin
    exp_t e;
    int   seen;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    bcd_in    = '0;
    #1;
    check_reset_outputs("reset");
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Zero and directed values with fixed latency.
    convert("zero", 12'h000, '{bin: 10'd0,   err: 1'b0});
    convert("d255", 12'h255, '{bin: 10'd255, err: 1'b0});
    convert("d999", 12'h999, '{bin: 10'd999, err: 1'b0});
    convert("d010", 12'h010, '{bin: 10'd10,  err: 1'b0});
    convert("d128", 12'h128, '{bin: 10'd128, err: 1'b0});

    // Exhaustive sweep of all valid 3-digit codes.
    for (int v = 0; v < 1000; v++) begin
      convert("sweep", to_bcd(v), model(to_bcd(v)));
    end

    // Invalid digits report zero with the error flag, then recovery.
    convert("bad_1A3", 12'h1A3, '{bin: 10'd0,  err: 1'b1});
    convert("bad_F00", 12'hF00, '{bin: 10'd0,  err: 1'b1});
    convert("after_bad", 12'h042, '{bin: 10'd42, err: 1'b0});

    // Backpressure: hold the result for 7 cycles while a new request knocks.
    out_ready = 1'b0;
    drive(12'h777, '{bin: 10'd777, err: 1'b0});
    await_result("stall", e);
    in_valid = 1'b1;
    bcd_in   = 12'h111;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("stall_out_valid",  {31'd0, out_valid},  32'd1);
      check("stall_binary_out", {22'd0, binary_out}, {22'd0, e.bin});
      check("stall_bcd_err",    {31'd0, bcd_err},    {31'd0, e.err});
      check("stall_in_ready",   {31'd0, in_ready},   32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("release_in_ready",  {31'd0, in_ready},  32'd1);
    check("release_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (LATENCY + 3) begin
      tick();
      check("no_stall_request_result", {31'd0, out_valid}, 32'd0);
    end

    // Reset during CONV drops the conversion.
    in_valid = 1'b1;
    bcd_in   = 12'h500;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_conv_reset");
    repeat (2) tick();
    rst_n = 1'b1;
    seen  = 0;
    repeat (2 * LATENCY) begin
      tick();
      if (out_valid) seen++;
    end
    check("no_result_after_reset", seen, 0);
    convert("after_reset", 12'h003, '{bin: 10'd3, err: 1'b0});

    check("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
